// File: rtl/inertial_filter.sv
// inertial_filter: per-channel inertial/transport delay with glitch flagging and a saturating reject count
module inertial_filter #(
    parameter int CH    = 4,
    parameter int DELAY = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [CH-1:0]    a,
    output logic [CH-1:0]    y,
    output logic [CH-1:0]    glitch,
    output logic [CNT_W-1:0] glitch_total,
    input  logic             glitch_clr
);
    localparam int CW   = DELAY > 1 ? $clog2(DELAY) : 1;
    localparam int SW   = DELAY > 1 ? DELAY - 1 : 1;
    localparam int PW   = $clog2(CH + 1) + 1;
    localparam int SUMW = CNT_W + PW;

    logic [CW-1:0]    cnt   [CH];
    logic [CW-1:0]    cnt_n [CH];
    logic [SW-1:0]    sr    [CH];
    logic [SW-1:0]    sr_n  [CH];
    logic [CH-1:0]    y_n, g_n, tap;
    logic [PW-1:0]    pop;
    logic [SUMW-1:0]  sum;
    logic [CNT_W-1:0] total_n;

    always_comb begin
        y_n = y;
        g_n = '0;
        pop = '0;
        for (int i = 0; i < CH; i++) begin
            sr_n[i]    = sr[i];
            sr_n[i][0] = a[i];
            for (int k = 1; k < SW; k++) sr_n[i][k] = sr[i][k-1];
            tap[i]  = DELAY == 1 ? a[i] : sr[i][SW-1];
            cnt_n[i] = '0;
            if (mode)
                y_n[i] = tap[i];
            else if (a[i] != y[i]) begin
                if (cnt[i] == CW'(DELAY - 1))
                    y_n[i] = a[i];
                else
                    cnt_n[i] = cnt[i] + CW'(1);
            end else
                g_n[i] = cnt[i] != '0;
            pop = pop + PW'(g_n[i]);
        end
        sum     = SUMW'(glitch_total) + SUMW'(pop);
        // any carry beyond CNT_W bits means the counter has saturated
        total_n = glitch_clr ? '0 : (|sum[SUMW-1:CNT_W]) ? '1 : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y            <= '0;
            glitch       <= '0;
            glitch_total <= '0;
            for (int i = 0; i < CH; i++) begin
                cnt[i] <= '0;
                sr[i]  <= '0;
            end
        end else begin
            y            <= y_n;
            glitch       <= g_n;
            glitch_total <= total_n;
            for (int i = 0; i < CH; i++) begin
                cnt[i] <= cnt_n[i];
                sr[i]  <= sr_n[i];
            end
        end
    end
endmodule

// File: tb/tb_inertial_filter.sv
// tb_inertial_filter: directed stimulus checked against a run-length/history model every cycle
module tb_inertial_filter;
    localparam int CH = 4, DELAY = 4, CNT_W = 8, MAXV = 255;

    logic             clk = 0, rst_n = 0, mode = 0, glitch_clr = 0;
    logic [CH-1:0]    a = '0;
    logic [CH-1:0]    y, glitch;
    logic [CNT_W-1:0] glitch_total;

    int tests = 0, fails = 0;
    bit [CH-1:0] m_y, m_g;
    int          m_tot;
    int          run [CH];
    bit [CH-1:0] q [$];

    inertial_filter #(.CH(CH), .DELAY(DELAY), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .a(a), .y(y),
        .glitch(glitch), .glitch_total(glitch_total), .glitch_clr(glitch_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_y = '0; m_g = '0; m_tot = 0;
        for (int i = 0; i < CH; i++) run[i] = 0;
        q.delete();
        for (int i = 0; i < DELAY - 1; i++) q.push_back('0);
    endtask

    // y tracks the input once it has differed from y for DELAY consecutive samples
    task automatic model_step();
        bit [CH-1:0] tap;
        int pc;
        if (!rst_n) begin model_reset(); return; end
        q.push_back(a);
        tap = q[0];
        void'(q.pop_front());
        pc = 0;
        for (int i = 0; i < CH; i++) begin
            m_g[i] = 0;
            if (mode) begin
                m_y[i] = tap[i];
                run[i] = 0;
            end else if (a[i] != m_y[i]) begin
                run[i]++;
                if (run[i] == DELAY) begin m_y[i] = a[i]; run[i] = 0; end
            end else begin
                m_g[i] = run[i] > 0;
                run[i] = 0;
            end
            pc += int'(m_g[i]);
        end
        m_tot = glitch_clr ? 0 : (m_tot + pc > MAXV ? MAXV : m_tot + pc);
    endtask

    task automatic check_model();
        chk("y", int'(y), int'(m_y));
        chk("glitch", int'(glitch), int'(m_g));
        chk("total", int'(glitch_total), m_tot);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1 check_model();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_y", int'(y), 0);
        chk("rst_glitch", int'(glitch), 0);
        chk("rst_total", int'(glitch_total), 0);
        rst_n = 1;

        // inertial pass on ch0
        a = 4'b0001;
        for (int i = 0; i < 3; i++) begin tick(); chk("t1_y0_low", int'(y[0]), 0); end
        tick(); chk("t1_y0_rise", int'(y[0]), 1);
        ticks(6);
        chk("t1_total", int'(glitch_total), 0);

        // inertial reject on ch1
        a = 4'b0011;
        ticks(3);
        a = 4'b0001;
        tick();
        chk("t2_glitch", int'(glitch), 4'b0010);
        chk("t2_total", int'(glitch_total), 1);
        chk("t2_y1", int'(y[1]), 0);
        tick();
        chk("t2_glitch_off", int'(glitch), 0);

        // transport pulse on ch2
        mode = 1;
        a = 4'b0101;
        ticks(2);
        a = 4'b0001;
        tick(); chk("t3_y2_p2", int'(y[2]), 0);
        tick(); chk("t3_y2_p3", int'(y[2]), 1);
        tick(); chk("t3_y2_p4", int'(y[2]), 1);
        tick(); chk("t3_y2_p5", int'(y[2]), 0);
        chk("t3_glitch", int'(glitch), 0);

        // multi-channel rejects and saturation
        mode = 0;
        a = 4'b0000;
        ticks(6);
        for (int p = 0; p < 65; p++) begin
            a = 4'b1111; ticks(3);
            a = 4'b0000; tick();
            if (p == 0) begin
                chk("t4_glitch_all", int'(glitch), 4'b1111);
                chk("t4_total_5", int'(glitch_total), 5);
            end
        end
        chk("t4_saturate", int'(glitch_total), 255);
        a = 4'b1111; ticks(3);
        a = 4'b0000; glitch_clr = 1; tick();
        chk("t4_clr_glitch", int'(glitch), 4'b1111);
        chk("t4_clr_total", int'(glitch_total), 0);
        glitch_clr = 0;
        tick();

        // asynchronous reset mid-pulse
        a = 4'b1000;
        tick(); a = 4'b1001; a = 4'b1000; tick();
        #2 rst_n = 0;
        model_reset();
        #1;
        chk("t5_rst_y", int'(y), 0);
        chk("t5_rst_glitch", int'(glitch), 0);
        chk("t5_rst_total", int'(glitch_total), 0);
        ticks(2);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin tick(); chk("t5_y3_low", int'(y[3]), 0); end
        tick(); chk("t5_y3_rise", int'(y[3]), 1);

        // mode switch mid-count
        a = 4'b1001;
        ticks(2);
        mode = 1;
        tick(); chk("t6_tap_old", int'(y[0]), 0);
        tick(); chk("t6_tap_new", int'(y[0]), 1);
        ticks(2);
        a = 4'b1000;
        ticks(3);
        chk("t6_tr_hold", int'(y[0]), 1);
        mode = 0;
        tick(); chk("t6_inert_hold", int'(y[0]), 1);
        tick(); chk("t6_inert_2", int'(y[0]), 1);
        tick(); chk("t6_inert_3", int'(y[0]), 1);
        tick(); chk("t6_inert_fall", int'(y[0]), 0);
        chk("t6_glitch", int'(glitch), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
